// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin sharing of one sync data memory plus switch/LED I/O word between ports A and B
//   clock/reset          : system clock, synchronous active-high reset
//   a_*/b_*              : requester ports (req, write, addr, wdata in; grant, rvalid, rdata out)
//   mem_addr/wdata/we    : memory drive; mem_rdata returns one cycle after the address
//   switches/leds        : board I/O at IO_ADDR
module data_memory_arbiter #(
  parameter logic [15:0] IO_ADDR = 16'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_write,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_grant,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_write,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_grant,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] switches,
  output logic [15:0] leds
);
  logic        last_b, p_valid, p_b, p_io, grant, sel_write, sel_io;
  logic [15:0] p_sw, a_hold, b_hold, rd;
  always_comb begin
    a_grant   = !reset & a_req & (!b_req | last_b);
    b_grant   = !reset & b_req & (!a_req | !last_b);
    grant     = a_grant | b_grant;
    mem_addr  = b_grant ? b_addr : a_addr;
    mem_wdata = b_grant ? b_wdata : a_wdata;
    sel_write = b_grant ? b_write : a_write;
    sel_io    = mem_addr == IO_ADDR;
    mem_we    = grant & sel_write & !sel_io;
    rd        = p_io ? p_sw : mem_rdata;
    // reset gating drops a read that was in flight when reset arrived
    a_rvalid  = !reset & p_valid & !p_b;
    b_rvalid  = !reset & p_valid & p_b;
    // mem_rdata is only live in the return cycle, so rdata is held otherwise
    a_rdata   = a_rvalid ? rd : a_hold;
    b_rdata   = b_rvalid ? rd : b_hold;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      last_b  <= 1'b1;
      p_valid <= 1'b0;
      p_b     <= 1'b0;
      p_io    <= 1'b0;
      p_sw    <= '0;
      a_hold  <= '0;
      b_hold  <= '0;
      leds    <= '0;
    end else begin
      if (grant) last_b <= b_grant;
      p_valid <= grant & !sel_write;
      p_b     <= b_grant;
      p_io    <= sel_io;
      p_sw    <= switches;
      if (grant & sel_write & sel_io) leds <= mem_wdata;
      if (a_rvalid) a_hold <= rd;
      if (b_rvalid) b_hold <= rd;
    end
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed checks of arbitration, memory drive, I/O decode and read return
module tb_data_memory_arbiter;
  logic        clock = 0, reset = 1;
  logic        a_req = 0, a_write = 0, b_req = 0, b_write = 0;
  logic [15:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0, switches = 0;
  logic        a_grant, a_rvalid, b_grant, b_rvalid, mem_we;
  logic [15:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata, leds;
  logic [15:0] mem [0:65535];
  int total = 0, bad = 0;

  data_memory_arbiter dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_grant(a_grant), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_grant(b_grant), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .switches(switches), .leds(leds)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) begin
      mem[16'h0010] <= 16'h1234;
      mem[16'h0001] <= 16'h0111;
      mem[16'h0002] <= 16'h0222;
      mem[16'h0030] <= 16'h0000;
      mem[16'h00FF] <= 16'h0000;
    end else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    a_req = 1; a_write = 1; a_addr = 16'h0040; a_wdata = 16'hAAAA;
    tick; tick; tick;
    #1;
    chk("rst a_grant", a_grant, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst a_rvalid", a_rvalid, 0);
    chk("rst b_rvalid", b_rvalid, 0);
    chk("rst a_rdata", a_rdata, 0);
    chk("rst b_rdata", b_rdata, 0);
    chk("rst leds", leds, 0);
    reset = 0; a_req = 0; a_write = 0;
    tick;
    // single A read
    a_req = 1; a_addr = 16'h0010;
    #1;
    chk("t1 a_grant", a_grant, 1);
    chk("t1 b_grant", b_grant, 0);
    chk("t1 mem_addr", mem_addr, 16'h0010);
    tick;
    a_req = 0;
    #1;
    chk("t1 a_rvalid", a_rvalid, 1);
    chk("t1 a_rdata", a_rdata, 16'h1234);
    chk("t1 b_rvalid", b_rvalid, 0);
    tick;
    chk("t1 a_rvalid low", a_rvalid, 0);
    chk("t1 a_rdata hold", a_rdata, 16'h1234);
    // contention after fresh reset
    reset = 1; tick; tick; reset = 0;
    a_req = 1; a_addr = 16'h0001; b_req = 1; b_write = 0; b_addr = 16'h0002;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin a_req = 0; b_req = 0; end
      #1;
      chk($sformatf("t2 a_grant %0d", i), a_grant, (i < 4 && i % 2 == 0) ? 1 : 0);
      chk($sformatf("t2 b_grant %0d", i), b_grant, (i < 4 && i % 2 == 1) ? 1 : 0);
      chk($sformatf("t2 a_rvalid %0d", i), a_rvalid, (i == 1 || i == 3) ? 1 : 0);
      chk($sformatf("t2 b_rvalid %0d", i), b_rvalid, (i == 2 || i == 4) ? 1 : 0);
      if (i == 1 || i == 3) chk($sformatf("t2 a_rdata %0d", i), a_rdata, 16'h0111);
      if (i == 2 || i == 4) chk($sformatf("t2 b_rdata %0d", i), b_rdata, 16'h0222);
      tick;
    end
    // B writes I/O word, then A reads it
    b_req = 1; b_write = 1; b_addr = 16'h00FF; b_wdata = 16'hBEEF;
    #1;
    chk("t3 b_grant", b_grant, 1);
    chk("t3 mem_we io", mem_we, 0);
    tick;
    b_req = 0; b_write = 0;
    #1;
    chk("t3 leds", leds, 16'hBEEF);
    switches = 16'h00A5; a_req = 1; a_write = 0; a_addr = 16'h00FF;
    #1;
    chk("t3 a_grant", a_grant, 1);
    tick;
    a_req = 0; switches = 16'h0F0F;
    #1;
    chk("t3 a_rvalid", a_rvalid, 1);
    chk("t3 a_rdata io", a_rdata, 16'h00A5);
    chk("t3 mem untouched", mem[16'h00FF], 16'h0000);
    // A writes memory, B reads it back
    a_req = 1; a_write = 1; a_addr = 16'h0020; a_wdata = 16'h5555;
    #1;
    chk("t4 mem_we", mem_we, 1);
    chk("t4 mem_wdata", mem_wdata, 16'h5555);
    tick;
    a_req = 0; a_write = 0; b_req = 1; b_write = 0; b_addr = 16'h0020;
    #1;
    chk("t4 b_grant", b_grant, 1);
    chk("t4 mem_addr", mem_addr, 16'h0020);
    tick;
    b_req = 0;
    #1;
    chk("t4 b_rvalid", b_rvalid, 1);
    chk("t4 b_rdata", b_rdata, 16'h5555);
    chk("t4 a_rdata kept", a_rdata, 16'h00A5);
    a_req = 1; a_write = 1; a_addr = 16'h00FE; a_wdata = 16'h1111;
    #1;
    chk("t4 mem_we fe", mem_we, 1);
    tick;
    a_req = 0; a_write = 0;
    #1;
    chk("t4 leds kept", leds, 16'hBEEF);
    // reset right after a read grant
    a_req = 1; a_addr = 16'h0010;
    #1;
    chk("t5 a_grant", a_grant, 1);
    tick;
    a_req = 0; reset = 1;
    #1;
    chk("t5 a_rvalid", a_rvalid, 0);
    tick;
    reset = 0;
    #1;
    chk("t5 a_rvalid after", a_rvalid, 0);
    chk("t5 leds", leds, 0);
    chk("t5 a_rdata", a_rdata, 0);
    a_req = 1; b_req = 1; b_addr = 16'h0002;
    #1;
    chk("t5 a_grant first", a_grant, 1);
    chk("t5 b_grant first", b_grant, 0);
    tick;
    // B withdraws a pending write while A holds priority
    a_req = 0;
    #1;
    chk("t6 b_grant alone", b_grant, 1);
    tick;
    a_req = 1; a_addr = 16'h0001; b_write = 1; b_addr = 16'h0030; b_wdata = 16'hDEAD;
    #1;
    chk("t6 a_grant", a_grant, 1);
    chk("t6 b_grant", b_grant, 0);
    chk("t6 mem_we", mem_we, 0);
    chk("t6 b_rvalid prev", b_rvalid, 1);
    chk("t6 b_rdata prev", b_rdata, 16'h0222);
    tick;
    a_req = 0; b_req = 0; b_write = 0;
    #1;
    chk("t6 mem_we withdrawn", mem_we, 0);
    chk("t6 a_rvalid", a_rvalid, 1);
    chk("t6 a_rdata", a_rdata, 16'h0111);
    chk("t6 b_rvalid", b_rvalid, 0);
    tick;
    a_req = 1; b_req = 1; b_addr = 16'h0002;
    #1;
    chk("t6 b_wins", b_grant, 1);
    chk("t6 a_loses", a_grant, 0);
    chk("t6 mem 30", mem[16'h0030], 16'h0000);
    tick;
    a_req = 0; b_req = 0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port data memory and its memory-mapped I/O word between two requesters: port A (CPU data port) and port B (secondary master, e.g. loader or display fetch).
- Grants at most one access per cycle, round-robin when both request.
- Drives the memory's address, write data and write enable, decodes the switch/LED I/O address, and returns read data to the originating port with a fixed latency.

Parameters:
- IO_ADDR, 16'd255, address decoded as I/O: reads return switches, writes update leds, memory never touched.

Ports:
- clock  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- a_req  in  1  port A access request, held until granted
- a_write  in  1  port A 1=write, 0=read; valid with a_req
- a_addr  in  16  port A word address
- a_wdata  in  16  port A write data
- a_grant  out  1  port A access accepted this cycle (combinational)
- a_rvalid  out  1  port A read data valid (registered)
- a_rdata  out  16  port A read data
- b_req, b_write, b_addr, b_wdata, b_grant, b_rvalid, b_rdata: same as port A, for port B
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  16  memory read data; synchronous, valid the cycle after the address is presented
- switches  in  16  board switches
- leds  out  16  board LEDs (registered)

Behaviour:
- Arbitration:
  - Register last_grant (A/B), reset to B, so A wins the first contention.
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port != last_grant.
  - last_grant updates at every posedge where a grant occurred.
  - At most one grant per cycle. No grants while reset is high.
- Request rules: a requester holds req/write/addr/wdata stable until it sees grant high. Deasserting req before grant is legal (withdraw). Dropping req after grant has no effect.
- Memory drive:
  - mem_addr and mem_wdata mux from the granted port; with no grant they hold port A's values, don't-care.
  - mem_we = grant & write & (addr != IO_ADDR).
- Writes: complete in the grant cycle; no rvalid. Write to IO_ADDR: leds <= wdata at that posedge; memory is not written.
- Reads: granted in cycle N; pipeline register {valid, port, is_io, sw_snap} captured at the end of N (sw_snap = switches sampled at that edge). In cycle N+1:
  - rvalid is high for exactly one cycle on the originating port.
  - rdata = is_io ? sw_snap : mem_rdata.
  - Latency is exactly 1 cycle from grant to rvalid.
  - Back-to-back reads are fully pipelined: one read per cycle, in grant order.
- rdata of a port holds its last returned value when rvalid is low. Behaviour of the non-addressed port's rdata is unchanged.
- IO_ADDR read returns switches, never leds. A read of IO_ADDR immediately after a write to IO_ADDR still returns switches.
- Reset values: a_grant=b_grant=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, leds=0, mem_we=0, last_grant=B, pipeline valid=0.
- Reset mid-operation: a read granted in the cycle before reset asserts returns no rvalid; in-flight state is discarded.
- Throughput: with both ports continuously requesting, grants alternate A,B,A,B; each port gets 50%.

Test Plan:
- Reset, then A reads 0x0010 (memory preloaded 0x1234) -> a_grant high in the request cycle; a_rvalid high exactly 1 cycle later with a_rdata=0x1234; b_rvalid stays 0.
- A and B both request reads (A 0x0001, B 0x0002) continuously for 4 cycles after reset -> grants A,B,A,B; rvalids alternate one cycle behind with the correct data per port.
- B writes 0xBEEF to 0x00FF -> mem_we stays 0, leds=0xBEEF next cycle. A then reads 0x00FF with switches=0x00A5 -> a_rdata=0x00A5.
- A writes 0x5555 to 0x0020, then B reads 0x0020 next cycle -> b_rdata=0x5555; A writes 0x1111 to 0x00FE -> mem_we=1, leds unchanged.
- A read granted, reset asserted the next cycle -> no a_rvalid, leds=0, next contention grants A first.
- B requests and withdraws req before a grant while A holds priority -> no write to memory, no b_rvalid, last_grant unchanged by B.
